// File: rtl/flags_pkg.sv
// Shared constants for the processor flags unit: default flag layout and
// stack-pointer width helper.
package flags_pkg;

  localparam int unsigned NFLAGS_DEFAULT = 4;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_G = 2;
  localparam int unsigned FLAG_E = 1;
  localparam int unsigned FLAG_Z = 0;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned sp_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flags_stack.sv
// Saturating LIFO of flag vectors with full/empty decode and a sticky
// overflow/underflow/conflict error flag.
module flags_stack
  import flags_pkg::*;
#(
  parameter int unsigned WIDTH = NFLAGS_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         err_clr,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [sp_width(DEPTH)-1:0]   sp,
  output logic                         full,
  output logic                         empty,
  output logic                         err
);

  localparam int unsigned SPW = sp_width(DEPTH);
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic             wr_en;

  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);
  assign sp    = sp_q;
  assign err   = err_q;
  assign dout  = empty ? '0 : mem_q[AW'(sp_q - SPW'(1))];

  // Clear is applied first so a same-cycle error event wins.
  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    wr_en = 1'b0;
    if (err_clr) err_d = 1'b0;
    if (push && pop) begin
      err_d = 1'b1;
    end else if (push) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + SPW'(1);
      end
    end else if (pop) begin
      if (empty) err_d = 1'b1;
      else       sp_d  = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[AW'(sp_q)] <= din;
  end

endmodule

// File: rtl/flags_unit.sv
// Processor flags register with per-bit write enables, carry-temp latch for
// gated ALU carry-in, and a save/restore stack for call/interrupt context.
module flags_unit
  import flags_pkg::*;
#(
  parameter int unsigned NFLAGS      = NFLAGS_DEFAULT,
  parameter int unsigned CARRY_IDX   = FLAG_C,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NFLAGS-1:0]                  flags_in,
  input  logic [NFLAGS-1:0]                  flags_we,
  input  logic                               itemp,
  input  logic                               cin_en,
  input  logic                               push,
  input  logic                               pop,
  input  logic                               err_clr,
  output logic [NFLAGS-1:0]                  flags,
  output logic                               cin,
  output logic [sp_width(STACK_DEPTH)-1:0]   sp,
  output logic                               stk_full,
  output logic                               stk_empty,
  output logic                               stk_err
);

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic              ctemp_q, ctemp_d;
  logic [NFLAGS-1:0] stk_dout;
  logic              pop_eff;

  flags_stack #(
    .WIDTH (NFLAGS),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .err_clr (err_clr),
    .din     (flags_q),
    .dout    (stk_dout),
    .sp      (sp),
    .full    (stk_full),
    .empty   (stk_empty),
    .err     (stk_err)
  );

  // Only a legal pop (not conflicting, not underflowing) overrides the write.
  assign pop_eff = pop && !push && !stk_empty;

  always_comb begin
    flags_d = (flags_q & ~flags_we) | (flags_in & flags_we);
    if (pop_eff) flags_d = stk_dout;
    ctemp_d = ctemp_q;
    if (itemp) ctemp_d = flags_q[CARRY_IDX];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      ctemp_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      ctemp_q <= ctemp_d;
    end
  end

  assign flags = flags_q;
  assign cin   = ctemp_q & cin_en;

endmodule

// File: tb/tb_flags_unit.sv
// Directed self-checking bench for flags_unit at default parameters.
module tb_flags_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] flags_in, flags_we;
  logic       itemp, cin_en, push, pop, err_clr;
  logic [3:0] flags;
  logic       cin;
  logic [2:0] sp;
  logic       stk_full, stk_empty, stk_err;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  flags_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flags_in  (flags_in),
    .flags_we  (flags_we),
    .itemp     (itemp),
    .cin_en    (cin_en),
    .push      (push),
    .pop       (pop),
    .err_clr   (err_clr),
    .flags     (flags),
    .cin       (cin),
    .sp        (sp),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_err   (stk_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flags_we = 4'b0000; flags_in = 4'b0000;
    itemp = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic wr(input logic [3:0] v);
    idle();
    flags_we = 4'b1111; flags_in = v;
    tick();
  endtask

  task automatic test_reset();
    idle(); cin_en = 1'b1; push = 1'b1;
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1; idle(); tick();
    checks++; if (flags !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b want 0000", flags); end
    checks++; if (sp !== 3'd0) begin fails++; $display("FAIL reset_sp got %0d want 0", sp); end
    checks++; if (stk_empty !== 1'b1 || stk_full !== 1'b0) begin fails++; $display("FAIL reset_empty_full got %b%b want 10", stk_empty, stk_full); end
    checks++; if (stk_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", stk_err); end
    checks++; if (cin !== 1'b0) begin fails++; $display("FAIL reset_cin got %b want 0", cin); end
  endtask

  task automatic test_masked_write();
    idle(); cin_en = 1'b0;
    flags_in = 4'b1111; flags_we = 4'b1010; tick();
    checks++; if (flags !== 4'b1010) begin fails++; $display("FAIL masked_write got %b want 1010", flags); end
    idle(); itemp = 1'b1; cin_en = 1'b1; tick();
    checks++; if (cin !== 1'b1) begin fails++; $display("FAIL cin_after_itemp got %b want 1", cin); end
    idle(); cin_en = 1'b0; #1;
    checks++; if (cin !== 1'b0) begin fails++; $display("FAIL cin_gate_comb got %b want 0", cin); end
  endtask

  task automatic test_ctemp_order();
    // ctemp is 1 from the previous test; clear flags while holding it.
    wr(4'b0000);
    idle(); cin_en = 1'b1; itemp = 1'b1; flags_we = 4'b1000; flags_in = 4'b1000; tick();
    checks++; if (flags !== 4'b1000) begin fails++; $display("FAIL ctemp_order_flags got %b want 1000", flags); end
    checks++; if (cin !== 1'b0) begin fails++; $display("FAIL ctemp_order_cin got %b want 0", cin); end
    idle(); itemp = 1'b1; tick();
    checks++; if (cin !== 1'b1) begin fails++; $display("FAIL ctemp_second_latch got %b want 1", cin); end
    idle(); cin_en = 1'b0;
  endtask

  task automatic test_save_restore();
    wr(4'b0101);
    idle(); push = 1'b1; tick();
    checks++; if (sp !== 3'd1) begin fails++; $display("FAIL sr_push1_sp got %0d want 1", sp); end
    wr(4'b1010);
    idle(); push = 1'b1; tick();
    wr(4'b0011);
    checks++; if (flags !== 4'b0011 || sp !== 3'd2) begin fails++; $display("FAIL sr_pre_pop got %b/%0d want 0011/2", flags, sp); end
    idle(); pop = 1'b1; tick();
    checks++; if (flags !== 4'b1010 || sp !== 3'd1) begin fails++; $display("FAIL sr_pop1 got %b/%0d want 1010/1", flags, sp); end
    idle(); pop = 1'b1; tick();
    checks++; if (flags !== 4'b0101 || sp !== 3'd0) begin fails++; $display("FAIL sr_pop2 got %b/%0d want 0101/0", flags, sp); end
    checks++; if (stk_empty !== 1'b1 || stk_err !== 1'b0) begin fails++; $display("FAIL sr_empty_err got %b%b want 10", stk_empty, stk_err); end
    idle();
  endtask

  task automatic test_overflow_underflow();
    wr(4'b0001);
    // Each push saves the pre-edge flags while writing the next value.
    for (int i = 0; i < 5; i++) begin
      idle(); push = 1'b1; flags_we = 4'b1111; flags_in = 4'(i + 2); tick();
    end
    checks++; if (sp !== 3'd4 || stk_full !== 1'b1) begin fails++; $display("FAIL ovf_sp_full got %0d/%b want 4/1", sp, stk_full); end
    checks++; if (stk_err !== 1'b1) begin fails++; $display("FAIL ovf_err got %b want 1", stk_err); end
    checks++; if (flags !== 4'b0110) begin fails++; $display("FAIL ovf_write_proceeds got %b want 0110", flags); end
    idle(); err_clr = 1'b1; tick();
    checks++; if (stk_err !== 1'b0) begin fails++; $display("FAIL err_clr got %b want 0", stk_err); end
    for (int i = 0; i < 4; i++) begin
      idle(); pop = 1'b1; tick();
      checks++; if (flags !== 4'(4 - i)) begin fails++; $display("FAIL pop_seq%0d got %b want %b", i, flags, 4'(4 - i)); end
    end
    checks++; if (stk_err !== 1'b0 || stk_empty !== 1'b1) begin fails++; $display("FAIL pop_drain got err=%b empty=%b want 0/1", stk_err, stk_empty); end
    idle(); pop = 1'b1; tick();
    checks++; if (sp !== 3'd0 || stk_err !== 1'b1) begin fails++; $display("FAIL unf got %0d/%b want 0/1", sp, stk_err); end
    checks++; if (flags !== 4'b0001) begin fails++; $display("FAIL unf_flags got %b want 0001", flags); end
    idle(); pop = 1'b1; flags_we = 4'b0100; flags_in = 4'b0100; tick();
    checks++; if (flags !== 4'b0101) begin fails++; $display("FAIL unf_write_proceeds got %b want 0101", flags); end
    idle(); err_clr = 1'b1; tick();
  endtask

  task automatic test_conflict_priority();
    wr(4'b0111);
    idle(); push = 1'b1; tick();
    wr(4'b1001);
    idle(); push = 1'b1; tick();
    wr(4'b0000);
    idle(); push = 1'b1; pop = 1'b1; err_clr = 1'b1; tick();
    checks++; if (sp !== 3'd2 || stk_err !== 1'b1) begin fails++; $display("FAIL conflict got %0d/%b want 2/1", sp, stk_err); end
    checks++; if (flags !== 4'b0000) begin fails++; $display("FAIL conflict_flags got %b want 0000", flags); end
    idle(); pop = 1'b1; flags_we = 4'b1111; flags_in = 4'b1111; tick();
    checks++; if (flags !== 4'b1001 || sp !== 3'd1) begin fails++; $display("FAIL pop_priority got %b/%0d want 1001/1", flags, sp); end
    idle(); itemp = 1'b1; tick();
    idle(); push = 1'b1; flags_we = 4'b1111; flags_in = 4'b1111; cin_en = 1'b1;
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    checks++; if (flags !== 4'b0000 || sp !== 3'd0) begin fails++; $display("FAIL midseq_reset got %b/%0d want 0000/0", flags, sp); end
    checks++; if (stk_err !== 1'b0 || stk_empty !== 1'b1 || cin !== 1'b0) begin fails++; $display("FAIL midseq_reset_status got err=%b empty=%b cin=%b want 0/1/0", stk_err, stk_empty, cin); end
    idle(); cin_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; cin_en = 1'b0; idle();
    test_reset();
    test_masked_write();
    test_ctemp_order();
    test_save_restore();
    test_overflow_underflow();
    test_conflict_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
